// File: rtl/vending_controller.sv
// rtl/vending_controller.sv - coin-operated vending FSM with per-item stock and change payout
module vending_controller #(
    parameter int NUM_ITEMS  = 4,
    parameter int CW         = 8,
    parameter int MAX_CREDIT = 200,
    parameter int TIMEOUT    = 1000,
    parameter int STOCK_W    = 4,
    localparam int IW        = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    coin_valid,
    input  logic [CW-1:0]           coin_value,
    input  logic                    select_valid,
    input  logic [IW-1:0]           select_id,
    input  logic                    cancel,
    input  logic [NUM_ITEMS*CW-1:0] price_table,
    input  logic                    restock_valid,
    input  logic [IW-1:0]           restock_id,
    input  logic [STOCK_W-1:0]      restock_qty,
    output logic [CW-1:0]           credit,
    output logic                    vend_valid,
    output logic [IW-1:0]           vend_id,
    output logic                    change_valid,
    output logic [CW-1:0]           change_amt,
    output logic                    coin_reject,
    output logic                    err_sold_out,
    output logic                    err_insufficient,
    output logic [1:0]              state
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW:0]      MAX_SUM   = (CW+1)'(MAX_CREDIT);
    localparam logic [STOCK_W:0] STOCK_MAX = {1'b0, {STOCK_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        credit_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [CW-1:0]        remainder_q, remainder_d;
    logic [CW-1:0]        payout_q, payout_d;
    logic [IW-1:0]        item_q, item_d;
    logic                 vend_valid_d, change_valid_d, coin_reject_d;
    logic                 err_sold_out_d, err_insufficient_d;
    logic [IW-1:0]        vend_id_d;
    logic [CW-1:0]        change_amt_d;
    logic                 dec_en;

    logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
    logic [STOCK_W:0]     stock_sum;
    logic [CW-1:0]        price [NUM_ITEMS];

    logic                 sel_ok, sel_out, coin_nz;
    logic [CW-1:0]        sel_price;
    logic [STOCK_W-1:0]   sel_stock;
    logic [CW:0]          coin_sum;

    assign state = state_q;

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            price[i] = price_table[i*CW +: CW];
        end
    end

    // Out-of-range selections read as zero stock, so they report sold out.
    assign sel_ok    = int'(select_id) < NUM_ITEMS;
    assign sel_price = sel_ok ? price[select_id] : '0;
    assign sel_stock = sel_ok ? stock_q[select_id] : '0;
    assign sel_out   = (sel_stock == '0);
    assign coin_nz   = coin_valid && (coin_value != '0);
    assign coin_sum  = {1'b0, credit} + {1'b0, coin_value};

    always_comb begin
        state_d            = state_q;
        credit_d           = credit;
        timer_d            = timer_q;
        remainder_d        = remainder_q;
        payout_d           = payout_q;
        item_d             = item_q;
        vend_valid_d       = 1'b0;
        vend_id_d          = '0;
        change_valid_d     = 1'b0;
        change_amt_d       = '0;
        coin_reject_d      = 1'b0;
        err_sold_out_d     = 1'b0;
        err_insufficient_d = 1'b0;
        dec_en             = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (coin_nz) begin
                    if (coin_value <= CW'(MAX_CREDIT)) begin
                        credit_d = coin_value;
                        timer_d  = '0;
                        state_d  = S_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
                if (select_valid) begin
                    if (sel_out) err_sold_out_d     = 1'b1;
                    else         err_insufficient_d = 1'b1;
                end
            end
            S_CREDIT: begin
                if (cancel) begin
                    coin_reject_d = coin_nz;
                    payout_d      = credit;
                    credit_d      = '0;
                    timer_d       = '0;
                    state_d       = S_CHANGE;
                end else if (select_valid) begin
                    coin_reject_d = coin_nz;
                    timer_d       = '0;
                    if (sel_out) begin
                        err_sold_out_d = 1'b1;
                    end else if (credit < sel_price) begin
                        err_insufficient_d = 1'b1;
                    end else begin
                        item_d      = select_id;
                        remainder_d = credit - sel_price;
                        credit_d    = '0;
                        state_d     = S_VEND;
                    end
                end else if (coin_nz && (coin_sum <= MAX_SUM)) begin
                    credit_d = coin_sum[CW-1:0];
                    timer_d  = '0;
                end else begin
                    coin_reject_d = coin_nz;
                    if (timer_q == TW'(TIMEOUT - 1)) begin
                        payout_d = credit;
                        credit_d = '0;
                        timer_d  = '0;
                        state_d  = S_CHANGE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            // Pulses leave on the exit edge so a reset during VEND/CHANGE forfeits them.
            S_VEND: begin
                coin_reject_d = coin_nz;
                vend_valid_d  = 1'b1;
                vend_id_d     = item_q;
                dec_en        = 1'b1;
                credit_d      = '0;
                remainder_d   = '0;
                if (remainder_q != '0) begin
                    payout_d = remainder_q;
                    state_d  = S_CHANGE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHANGE: begin
                coin_reject_d  = coin_nz;
                change_valid_d = 1'b1;
                change_amt_d   = payout_q;
                payout_d       = '0;
                credit_d       = '0;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Restock and vend decrement combine before saturating.
    always_comb begin
        stock_sum = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_sum = {1'b0, stock_q[i]};
            if (restock_valid && (int'(restock_id) == i))
                stock_sum = stock_sum + {1'b0, restock_qty};
            if (dec_en && (int'(item_q) == i))
                stock_sum = stock_sum - (STOCK_W+1)'(1);
            stock_d[i] = (stock_sum > STOCK_MAX) ? {STOCK_W{1'b1}} : stock_sum[STOCK_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            credit           <= '0;
            timer_q          <= '0;
            remainder_q      <= '0;
            payout_q         <= '0;
            item_q           <= '0;
            vend_valid       <= 1'b0;
            vend_id          <= '0;
            change_valid     <= 1'b0;
            change_amt       <= '0;
            coin_reject      <= 1'b0;
            err_sold_out     <= 1'b0;
            err_insufficient <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= '0;
        end else begin
            state_q          <= state_d;
            credit           <= credit_d;
            timer_q          <= timer_d;
            remainder_q      <= remainder_d;
            payout_q         <= payout_d;
            item_q           <= item_d;
            vend_valid       <= vend_valid_d;
            vend_id          <= vend_id_d;
            change_valid     <= change_valid_d;
            change_amt       <= change_amt_d;
            coin_reject      <= coin_reject_d;
            err_sold_out     <= err_sold_out_d;
            err_insufficient <= err_insufficient_d;
            for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= stock_d[i];
        end
    end
endmodule

// File: tb/tb_vending_controller.sv
// tb/tb_vending_controller.sv - vector table and scoreboard bench for vending_controller
`timescale 1ns/1ps
module tb_vending_controller;
    localparam int NI = 4;
    localparam int CW = 8;
    localparam int TO = 20;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          coin_valid;
    logic [CW-1:0] coin_value;
    logic          select_valid;
    logic [1:0]    select_id;
    logic          cancel;
    logic [NI*CW-1:0] price_table;
    logic          restock_valid;
    logic [1:0]    restock_id;
    logic [SW-1:0] restock_qty;
    logic [CW-1:0] credit;
    logic          vend_valid;
    logic [1:0]    vend_id;
    logic          change_valid;
    logic [CW-1:0] change_amt;
    logic          coin_reject;
    logic          err_sold_out;
    logic          err_insufficient;
    logic [1:0]    state;

    always #5 clk = ~clk;

    vending_controller #(
        .NUM_ITEMS(NI), .CW(CW), .MAX_CREDIT(200), .TIMEOUT(TO), .STOCK_W(SW)
    ) dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .select_valid(select_valid), .select_id(select_id),
        .cancel(cancel), .price_table(price_table),
        .restock_valid(restock_valid), .restock_id(restock_id), .restock_qty(restock_qty),
        .credit(credit), .vend_valid(vend_valid), .vend_id(vend_id),
        .change_valid(change_valid), .change_amt(change_amt),
        .coin_reject(coin_reject), .err_sold_out(err_sold_out),
        .err_insufficient(err_insufficient), .state(state)
    );

    typedef struct {
        string name;
        int rst, cv, cval, sv, sid, can, rv, rid, rq;
        int cr, vd, vi, ch, am, rj, so, ins, st;
        int sidx, sexp;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(string n, int rst, int cv, int cval, int sv, int sid, int can,
                                int rv, int rid, int rq, int cr, int vd, int vi, int ch, int am,
                                int rj, int so, int ins, int st, int sidx = -1, int sexp = 0);
        vec_t v;
        v.name = n; v.rst = rst; v.cv = cv; v.cval = cval; v.sv = sv; v.sid = sid; v.can = can;
        v.rv = rv; v.rid = rid; v.rq = rq; v.cr = cr; v.vd = vd; v.vi = vi; v.ch = ch; v.am = am;
        v.rj = rj; v.so = so; v.ins = ins; v.st = st; v.sidx = sidx; v.sexp = sexp;
        return v;
    endfunction

    task automatic check_val(input string n, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, want);
        end
    endtask

    task automatic drive(input vec_t v);
        reset         = (v.rst != 0);
        coin_valid    = (v.cv != 0);
        coin_value    = CW'(v.cval);
        select_valid  = (v.sv != 0);
        select_id     = 2'(v.sid);
        cancel        = (v.can != 0);
        restock_valid = (v.rv != 0);
        restock_id    = 2'(v.rid);
        restock_qty   = SW'(v.rq);
    endtask

    task automatic apply(input vec_t v);
        vec_t        e;
        logic [24:0] act;
        logic [24:0] want;
        drive(v);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        act  = {credit, vend_valid, vend_id, change_valid, change_amt,
                coin_reject, err_sold_out, err_insufficient, state};
        want = {CW'(e.cr), 1'(e.vd), 2'(e.vi), 1'(e.ch), CW'(e.am),
                1'(e.rj), 1'(e.so), 1'(e.ins), 2'(e.st)};
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got cr=%0d vv=%b vid=%0d cv=%b amt=%0d rej=%b so=%b ins=%b st=%0d expected %h (got %h)",
                     e.name, credit, vend_valid, vend_id, change_valid, change_amt,
                     coin_reject, err_sold_out, err_insufficient, state, want, act);
        end
        if (e.sidx >= 0)
            check_val({e.name, "_stock"}, int'(dut.stock_q[2'(e.sidx)]), e.sexp);
    endtask

    task automatic run_timeout(input int first, input int restart_at, input int second);
        int n;
        apply(mk("to_coin", 0,1,first,0,0,0,0,0,0, first,0,0,0,0,0,0,0,1));
        for (int i = 0; i < restart_at; i++)
            apply(mk("to_wait", 0,0,0,0,0,0,0,0,0, first,0,0,0,0,0,0,0,1));
        if (restart_at > 0)
            apply(mk("to_restart", 0,1,second,0,0,0,0,0,0, first+second,0,0,0,0,0,0,0,1));
        drive(mk("idle", 0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
        n = 0;
        for (int i = 1; i <= 10*TO && n == 0; i++) begin
            @(posedge clk);
            #1;
            if (state == 2'd3) n = i;
        end
        check_val("timeout_cycles", n, TO);
        apply(mk("to_payout", 0,0,0,0,0,0,0,0,0, 0,0,0,1,first+second,0,0,0,0));
    endtask

    initial begin
        price_table = {8'd50, 8'd15, 8'd20, 8'd0};
        //                  name           rst cv val sv id can rv id qty  cr vd vi ch amt rj so ins st
        tbl.push_back(mk("reset",           1,0,0,  0,0,0, 0,0,0,   0,0,0,0,0,  0,0,0,0));
        tbl.push_back(mk("restock2",        0,0,0,  0,0,0, 1,2,3,   0,0,0,0,0,  0,0,0,0));
        tbl.push_back(mk("restock3",        0,0,0,  0,0,0, 1,3,2,   0,0,0,0,0,  0,0,0,0));
        tbl.push_back(mk("idle_soldout",    0,0,0,  1,1,0, 0,0,0,   0,0,0,0,0,  0,1,0,0));
        tbl.push_back(mk("idle_insuff",     0,0,0,  1,2,0, 0,0,0,   0,0,0,0,0,  0,0,1,0));
        tbl.push_back(mk("idle_coin_big",   0,1,250,0,0,0, 0,0,0,   0,0,0,0,0,  1,0,0,0));
        tbl.push_back(mk("idle_cancel",     0,0,0,  0,0,1, 0,0,0,   0,0,0,0,0,  0,0,0,0));
        tbl.push_back(mk("idle_coin_zero",  0,1,0,  0,0,0, 0,0,0,   0,0,0,0,0,  0,0,0,0));
        tbl.push_back(mk("coin10",          0,1,10, 0,0,0, 0,0,0,   10,0,0,0,0, 0,0,0,1));
        tbl.push_back(mk("coin10b",         0,1,10, 0,0,0, 0,0,0,   20,0,0,0,0, 0,0,0,1));
        tbl.push_back(mk("select2",         0,0,0,  1,2,0, 0,0,0,   0,0,0,0,0,  0,0,0,2));
        tbl.push_back(mk("vend2",           0,0,0,  0,0,0, 0,0,0,   0,1,2,0,0,  0,0,0,3));
        tbl.push_back(mk("change5",         0,0,0,  0,0,0, 0,0,0,   0,0,0,1,5,  0,0,0,0, 2,2));
        tbl.push_back(mk("coin195",         0,1,195,0,0,0, 0,0,0,   195,0,0,0,0,0,0,0,1));
        tbl.push_back(mk("coin_over",       0,1,10, 0,0,0, 0,0,0,   195,0,0,0,0,1,0,0,1));
        tbl.push_back(mk("coin_to_max",     0,1,5,  0,0,0, 0,0,0,   200,0,0,0,0,0,0,0,1));
        tbl.push_back(mk("coin_at_max",     0,1,1,  0,0,0, 0,0,0,   200,0,0,0,0,1,0,0,1));
        tbl.push_back(mk("credit_soldout",  0,0,0,  1,1,0, 0,0,0,   200,0,0,0,0,0,1,0,1));
        tbl.push_back(mk("cancel_sel_coin", 0,1,5,  1,2,1, 0,0,0,   0,0,0,0,0,  1,0,0,3));
        tbl.push_back(mk("refund200",       0,0,0,  0,0,0, 0,0,0,   0,0,0,1,200,0,0,0,0));
        tbl.push_back(mk("coin20",          0,1,20, 0,0,0, 0,0,0,   20,0,0,0,0, 0,0,0,1));
        tbl.push_back(mk("credit_insuff",   0,0,0,  1,3,0, 0,0,0,   20,0,0,0,0, 0,0,1,1));
        tbl.push_back(mk("sel_beats_coin",  0,1,5,  1,3,0, 0,0,0,   20,0,0,0,0, 1,0,1,1));
        tbl.push_back(mk("cancel20",        0,0,0,  0,0,1, 0,0,0,   0,0,0,0,0,  0,0,0,3));
        tbl.push_back(mk("coin_in_change",  0,1,5,  0,0,0, 0,0,0,   0,0,0,1,20, 1,0,0,0));
        tbl.push_back(mk("restock0",        0,0,0,  0,0,0, 1,0,1,   0,0,0,0,0,  0,0,0,0));
        tbl.push_back(mk("coin7",           0,1,7,  0,0,0, 0,0,0,   7,0,0,0,0,  0,0,0,1));
        tbl.push_back(mk("select_free",     0,0,0,  1,0,0, 0,0,0,   0,0,0,0,0,  0,0,0,2));
        tbl.push_back(mk("vend_ignores",    0,1,3,  1,1,1, 0,0,0,   0,1,0,0,0,  1,0,0,3, 0,0));
        tbl.push_back(mk("change7",         0,0,0,  0,0,0, 0,0,0,   0,0,0,1,7,  0,0,0,0));
        tbl.push_back(mk("coin15",          0,1,15, 0,0,0, 0,0,0,   15,0,0,0,0, 0,0,0,1));
        tbl.push_back(mk("select_exact",    0,0,0,  1,2,0, 0,0,0,   0,0,0,0,0,  0,0,0,2));
        tbl.push_back(mk("vend_exact",      0,0,0,  0,0,0, 0,0,0,   0,1,2,0,0,  0,0,0,0, 2,1));
        tbl.push_back(mk("after_exact",     0,0,0,  0,0,0, 0,0,0,   0,0,0,0,0,  0,0,0,0));
        tbl.push_back(mk("coin15b",         0,1,15, 0,0,0, 0,0,0,   15,0,0,0,0, 0,0,0,1));
        tbl.push_back(mk("select_b",        0,0,0,  1,2,0, 0,0,0,   0,0,0,0,0,  0,0,0,2));
        tbl.push_back(mk("reset_in_vend",   1,0,0,  0,0,0, 0,0,0,   0,0,0,0,0,  0,0,0,0, 2,0));
        tbl.push_back(mk("post_reset",      0,0,0,  0,0,0, 0,0,0,   0,0,0,0,0,  0,0,0,0));
        tbl.push_back(mk("coin30",          0,1,30, 0,0,0, 0,0,0,   30,0,0,0,0, 0,0,0,1));
        tbl.push_back(mk("cancel30",        0,0,0,  0,0,1, 0,0,0,   0,0,0,0,0,  0,0,0,3));
        tbl.push_back(mk("reset_in_change", 1,0,0,  0,0,0, 0,0,0,   0,0,0,0,0,  0,0,0,0));
        tbl.push_back(mk("post_reset2",     0,0,0,  0,0,0, 0,0,0,   0,0,0,0,0,  0,0,0,0));
        tbl.push_back(mk("restock1_14",     0,0,0,  0,0,0, 1,1,14,  0,0,0,0,0,  0,0,0,0, 1,14));
        tbl.push_back(mk("restock1_sat",    0,0,0,  0,0,0, 1,1,5,   0,0,0,0,0,  0,0,0,0, 1,15));
        tbl.push_back(mk("coin20b",         0,1,20, 0,0,0, 0,0,0,   20,0,0,0,0, 0,0,0,1));
        tbl.push_back(mk("select1",         0,0,0,  1,1,0, 0,0,0,   0,0,0,0,0,  0,0,0,2));
        tbl.push_back(mk("vend_restock_sat",0,0,0,  0,0,0, 1,1,3,   0,1,1,0,0,  0,0,0,0, 1,15));
        tbl.push_back(mk("coin20c",         0,1,20, 0,0,0, 0,0,0,   20,0,0,0,0, 0,0,0,1));
        tbl.push_back(mk("select1b",        0,0,0,  1,1,0, 0,0,0,   0,0,0,0,0,  0,0,0,2));
        tbl.push_back(mk("vend1",           0,0,0,  0,0,0, 0,0,0,   0,1,1,0,0,  0,0,0,0, 1,14));
        tbl.push_back(mk("coin20d",         0,1,20, 0,0,0, 0,0,0,   20,0,0,0,0, 0,0,0,1));
        tbl.push_back(mk("select1c",        0,0,0,  1,1,0, 0,0,0,   0,0,0,0,0,  0,0,0,2));
        tbl.push_back(mk("vend_restock_net",0,0,0,  0,0,0, 1,1,1,   0,1,1,0,0,  0,0,0,0, 1,14));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        run_timeout(25, 0, 0);
        run_timeout(25, 10, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
